// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the audio datapath blocks (receive
// deserializer, decimator, serializer).
//   AUDIO_WIDTH : native sample width of the audio path
//   LR_LEFT     : word-select level that marks the left channel
//   state_t     : I2S receive frame state
package audio_pkg;

  localparam int unsigned AUDIO_WIDTH = 16;
  localparam logic        LR_LEFT     = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SLOT,
    SHIFT,
    PAD
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for one asynchronous input,
// followed by a single-cycle edge detector on the synchronized level.
//   i_clk   : system clock
//   i_rst   : asynchronous reset, active-high
//   i_d     : asynchronous input
//   o_level : synchronized level (SYNC_STAGES cycles of delay)
//   o_rise  : one-cycle pulse on a 0->1 transition of o_level
//   o_fall  : one-cycle pulse on a 1->0 transition of o_level
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/audio_serial_to_parallel.sv
// audio_serial_to_parallel: I2S receive deserializer for the WM8731 ADC path.
// Oversamples BCLK/LRCK/DATA on CLOCK_50, assembles MSB-first left and right
// words (skipping the I2S one-bit delay) and presents both together with a
// one-cycle strobe. A word cut short by an early LRCK edge raises FRAME_ERR
// and suppresses that frame's output update.
//   CLOCK_50     : system clock, the only clock in the block
//   RESET        : asynchronous reset, active-high
//   AUD_BCLK     : codec bit clock (asynchronous)
//   AUD_ADCLRCK  : codec word select, low = left, high = right
//   AUD_ADCDAT   : codec serial data, changes on BCLK falling edge
//   AUD_L/AUD_R  : last complete left/right words
//   AUD_OUT      : mono feed to the decimator (copy of AUD_L)
//   SAMPLE_VALID : one-cycle pulse when AUD_L/AUD_R/AUD_OUT update
//   FRAME_ERR    : one-cycle pulse when a word is truncated
module audio_serial_to_parallel
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AUDIO_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] AUD_L,
  output logic [DATA_WIDTH-1:0] AUD_R,
  output logic [DATA_WIDTH-1:0] AUD_OUT,
  output logic                  SAMPLE_VALID,
  output logic                  FRAME_ERR
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic w_bclk_level_unused;
  logic w_bclk_rise;
  logic w_bclk_fall_unused;
  logic w_lr_now;
  logic w_lr_rise;
  logic w_lr_fall;
  logic w_data;
  logic w_data_rise_unused;
  logic w_data_fall_unused;
  logic w_lr_edge;

  // All three inputs use identical synchronizers so DATA stays aligned
  // with the BCLK rising edge that qualifies it.
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_d     (AUD_BCLK),
    .o_level (w_bclk_level_unused),
    .o_rise  (w_bclk_rise),
    .o_fall  (w_bclk_fall_unused)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_d     (AUD_ADCLRCK),
    .o_level (w_lr_now),
    .o_rise  (w_lr_rise),
    .o_fall  (w_lr_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_d     (AUD_ADCDAT),
    .o_level (w_data),
    .o_rise  (w_data_rise_unused),
    .o_fall  (w_data_fall_unused)
  );

  assign w_lr_edge = w_lr_rise | w_lr_fall;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_hold_l;
  logic [DATA_WIDTH-1:0] r_hold_r;
  logic                  r_left_ok;
  logic                  r_commit;
  logic [DATA_WIDTH-1:0] w_next_word;

  assign w_next_word = {r_shift[DATA_WIDTH-2:0], w_data};

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_left_ok    <= 1'b0;
      r_commit     <= 1'b0;
      AUD_L        <= '0;
      AUD_R        <= '0;
      AUD_OUT      <= '0;
      SAMPLE_VALID <= 1'b0;
      FRAME_ERR    <= 1'b0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      FRAME_ERR    <= 1'b0;
      r_commit     <= 1'b0;

      if (r_commit) begin
        AUD_L        <= r_hold_l;
        AUD_R        <= r_hold_r;
        AUD_OUT      <= r_hold_l;
        SAMPLE_VALID <= 1'b1;
      end

      case (r_state)
        IDLE, PAD: begin
          if (w_lr_edge) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            // A coincident BCLK rise is consumed as the one-bit delay.
            r_state   <= w_bclk_rise ? SHIFT : SLOT;
          end
        end

        SLOT, SHIFT: begin
          if (w_lr_edge) begin
            // Word cut short: drop it and poison the current frame.
            FRAME_ERR <= 1'b1;
            r_left_ok <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_state   <= w_bclk_rise ? SHIFT : SLOT;
          end else if (w_bclk_rise) begin
            if (r_state == SLOT) begin
              r_state <= SHIFT;
            end else begin
              r_shift <= w_next_word;
              if (r_bit_cnt < CNT_W'(DATA_WIDTH)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
              if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                r_state <= PAD;
                if (w_lr_now == LR_LEFT) begin
                  r_hold_l  <= w_next_word;
                  r_left_ok <= 1'b1;
                end else begin
                  r_hold_r  <= w_next_word;
                  r_commit  <= r_left_ok;
                  r_left_ok <= 1'b0;
                end
              end
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_serial_to_parallel.sv
module tb_audio_serial_to_parallel;

  localparam int HALF = 160;  // BCLK half period, 8 CLOCK_50 periods

  logic        clk;
  logic        rst;
  logic        bclk;
  logic        lrck;
  logic        dat;
  logic [15:0] aud_l;
  logic [15:0] aud_r;
  logic [15:0] aud_out;
  logic        sv;
  logic        fe;

  int total;
  int bad;
  int sv_cnt;
  int fe_cnt;

  audio_serial_to_parallel #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .CLOCK_50     (clk),
    .RESET        (rst),
    .AUD_BCLK     (bclk),
    .AUD_ADCLRCK  (lrck),
    .AUD_ADCDAT   (dat),
    .AUD_L        (aud_l),
    .AUD_R        (aud_r),
    .AUD_OUT      (aud_out),
    .SAMPLE_VALID (sv),
    .FRAME_ERR    (fe)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (sv === 1'b1) sv_cnt++;
    if (fe === 1'b1) fe_cnt++;
  end

  // One BCLK period; LRCK and DATA change with the falling edge.
  task automatic slot(input logic lr, input logic d);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    #HALF;
    bclk = 1'b1;
    #HALF;
  endtask

  // Slot 0 is the I2S delay bit, slots 1..16 carry the word MSB first.
  task automatic slots(input logic lr, input logic [15:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      slot(lr, (k >= 1 && k <= 16) ? w[16-k] : 1'b0);
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    slots(1'b0, l, 0, 31);
    slots(1'b1, r, 0, 31);
  endtask

  task automatic test_reset;
    int s0;
    int f0;
    total++; if (aud_l !== 16'h0000) begin bad++; $display("FAIL reset_l: got %h expected 0000", aud_l); end
    total++; if (aud_r !== 16'h0000) begin bad++; $display("FAIL reset_r: got %h expected 0000", aud_r); end
    total++; if (aud_out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h expected 0000", aud_out); end
    total++; if (sv !== 1'b0 || fe !== 1'b0) begin bad++; $display("FAIL reset_flags: got sv=%b fe=%b expected 0 0", sv, fe); end
    rst = 1'b0;
    #50;
    slots(1'b1, 16'h0000, 0, 31);
    s0 = sv_cnt;
    frame(16'h1111, 16'h2222);
    total++; if (sv_cnt - s0 !== 1) begin bad++; $display("FAIL reset_first_frame_sv: got %0d expected 1", sv_cnt - s0); end
    total++; if (aud_l !== 16'h1111) begin bad++; $display("FAIL reset_first_frame_l: got %h expected 1111", aud_l); end
    // Reset in the middle of a left word.
    s0 = sv_cnt;
    f0 = fe_cnt;
    slots(1'b0, 16'hFFFF, 0, 8);
    rst = 1'b1;
    #5;
    total++; if (aud_l !== 16'h0000) begin bad++; $display("FAIL midreset_l: got %h expected 0000", aud_l); end
    total++; if (aud_r !== 16'h0000) begin bad++; $display("FAIL midreset_r: got %h expected 0000", aud_r); end
    total++; if (aud_out !== 16'h0000) begin bad++; $display("FAIL midreset_out: got %h expected 0000", aud_out); end
    slots(1'b0, 16'hFFFF, 9, 12);
    rst = 1'b0;
    slots(1'b0, 16'hFFFF, 13, 31);
    slots(1'b1, 16'hFFFF, 0, 31);
    total++; if (sv_cnt - s0 !== 0) begin bad++; $display("FAIL postreset_sv: got %0d expected 0", sv_cnt - s0); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL postreset_fe: got %0d expected 0", fe_cnt - f0); end
    total++; if (aud_l !== 16'h0000) begin bad++; $display("FAIL postreset_l: got %h expected 0000", aud_l); end
  endtask

  task automatic test_nominal;
    int s0;
    int f0;
    s0 = sv_cnt;
    f0 = fe_cnt;
    frame(16'hA5C3, 16'h1234);
    total++; if (sv_cnt - s0 !== 1) begin bad++; $display("FAIL nominal_sv: got %0d expected 1", sv_cnt - s0); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL nominal_fe: got %0d expected 0", fe_cnt - f0); end
    total++; if (aud_l !== 16'hA5C3) begin bad++; $display("FAIL nominal_l: got %h expected a5c3", aud_l); end
    total++; if (aud_r !== 16'h1234) begin bad++; $display("FAIL nominal_r: got %h expected 1234", aud_r); end
    total++; if (aud_out !== 16'hA5C3) begin bad++; $display("FAIL nominal_out: got %h expected a5c3", aud_out); end
    slots(1'b1, 16'h0000, 0, 7);
    total++; if (aud_l !== 16'hA5C3 || aud_r !== 16'h1234) begin bad++; $display("FAIL nominal_hold: got %h/%h expected a5c3/1234", aud_l, aud_r); end
    total++; if (sv_cnt - s0 !== 1) begin bad++; $display("FAIL nominal_hold_sv: got %0d expected 1", sv_cnt - s0); end
  endtask

  task automatic test_alignment;
    frame(16'h8001, 16'h4000);
    total++; if (aud_l !== 16'h8001) begin bad++; $display("FAIL align_l: got %h expected 8001", aud_l); end
    total++; if (aud_r !== 16'h4000) begin bad++; $display("FAIL align_r: got %h expected 4000", aud_r); end
  endtask

  task automatic test_truncation;
    int s0;
    int f0;
    s0 = sv_cnt;
    f0 = fe_cnt;
    slots(1'b0, 16'hFFFF, 0, 10);
    slots(1'b1, 16'h5555, 0, 31);
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL trunc_fe: got %0d expected 1", fe_cnt - f0); end
    total++; if (sv_cnt - s0 !== 0) begin bad++; $display("FAIL trunc_sv: got %0d expected 0", sv_cnt - s0); end
    total++; if (aud_l !== 16'h8001 || aud_r !== 16'h4000) begin bad++; $display("FAIL trunc_hold: got %h/%h expected 8001/4000", aud_l, aud_r); end
    frame(16'h0F0F, 16'hF0F0);
    total++; if (sv_cnt - s0 !== 1) begin bad++; $display("FAIL trunc_recover_sv: got %0d expected 1", sv_cnt - s0); end
    total++; if (aud_l !== 16'h0F0F || aud_r !== 16'hF0F0) begin bad++; $display("FAIL trunc_recover: got %h/%h expected 0f0f/f0f0", aud_l, aud_r); end
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL trunc_recover_fe: got %0d expected 1", fe_cnt - f0); end
  endtask

  task automatic test_coincident;
    int s0;
    int f0;
    s0 = sv_cnt;
    f0 = fe_cnt;
    slots(1'b0, 16'h1357, 0, 31);
    bclk = 1'b0;
    dat  = 1'b0;
    #HALF;
    bclk = 1'b1;
    lrck = 1'b1;
    #HALF;
    slots(1'b1, 16'h7FFF, 1, 31);
    total++; if (aud_r !== 16'h7FFF) begin bad++; $display("FAIL coinc_r: got %h expected 7fff", aud_r); end
    total++; if (aud_l !== 16'h1357) begin bad++; $display("FAIL coinc_l: got %h expected 1357", aud_l); end
    total++; if (sv_cnt - s0 !== 1 || fe_cnt - f0 !== 0) begin bad++; $display("FAIL coinc_flags: got sv=%0d fe=%0d expected 1 0", sv_cnt - s0, fe_cnt - f0); end
  endtask

  task automatic test_back_to_back;
    int s0;
    int f0;
    s0 = sv_cnt;
    f0 = fe_cnt;
    for (int i = 0; i < 8; i++) begin
      frame(16'(i), 16'h8000 | 16'(i));
      total++; if (sv_cnt - s0 !== i + 1) begin bad++; $display("FAIL b2b_sv[%0d]: got %0d expected %0d", i, sv_cnt - s0, i + 1); end
      total++; if (aud_l !== 16'(i) || aud_r !== (16'h8000 | 16'(i))) begin bad++; $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, aud_l, aud_r, 16'(i), 16'h8000 | 16'(i)); end
    end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL b2b_fe: got %0d expected 0", fe_cnt - f0); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    sv_cnt = 0;
    fe_cnt = 0;
    rst    = 1'b1;
    bclk   = 1'b0;
    lrck   = 1'b0;
    dat    = 1'b0;
    #103;
    test_reset;
    test_nominal;
    test_alignment;
    test_truncation;
    test_coincident;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
